// File: rtl/fp_pkg.sv
// Shared FP16 definitions for the issue sequencer: op encodings, field
// widths and the issue FSM state type.
package fp_pkg;

   localparam logic [1:0] FP_ADD = 2'b00;
   localparam logic [1:0] FP_SUB = 2'b01;
   localparam logic [1:0] FP_MUL = 2'b10;
   localparam logic [1:0] FP_DIV = 2'b11;

   localparam int unsigned FP_SIGN_W = 1;
   localparam int unsigned FP_EXP_W  = 5;
   localparam int unsigned FP_MANT_W = 10;

   localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } issue_state_e;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 classifier: NaN, infinity and signed-zero detection.
module fp16_classify
   import fp_pkg::*;
(
   input  logic [15:0] val,
   output logic        is_nan,
   output logic        is_inf,
   output logic        is_zero
);

   logic [FP_EXP_W-1:0]  exp_f;
   logic [FP_MANT_W-1:0] mant_f;

   assign exp_f   = val[14:10];
   assign mant_f  = val[9:0];
   assign is_nan  = (exp_f == FP_EXP_ONES) && (mant_f != '0);
   assign is_inf  = (exp_f == FP_EXP_ONES) && (mant_f == '0);
   assign is_zero = (val[14:0] == '0);

endmodule

// File: rtl/fp_issue_ctrl.sv
// Sequencer in front of the floatingPoint unit: holds one op at the unit's
// inputs, waits its fixed latency, then returns the result with flags.
module fp_issue_ctrl
   import fp_pkg::*;
#(
   parameter int unsigned LAT_ADD = 3,
   parameter int unsigned LAT_SUB = 3,
   parameter int unsigned LAT_MUL = 3,
   parameter int unsigned LAT_DIV = 6
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic [1:0]  cmd_op,
   output logic [15:0] fp_a,
   output logic [15:0] fp_b,
   output logic [1:0]  fp_sel,
   input  logic [15:0] fp_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_nan,
   output logic        rsp_dz,
   output logic        busy
);

   issue_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [15:0]  fp_a_q, fp_a_d, fp_b_q, fp_b_d;
   logic [1:0]   fp_sel_q, fp_sel_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [15:0]  rsp_data_q, rsp_data_d;
   logic         rsp_nan_q, rsp_nan_d;
   logic         rsp_dz_q, rsp_dz_d;
   logic [3:0]   lat_sel;

   logic res_nan, res_inf_unused, res_zero_unused;
   logic b_nan_unused, b_inf_unused, b_zero;

   fp16_classify u_res_class (
      .val     (fp_result),
      .is_nan  (res_nan),
      .is_inf  (res_inf_unused),
      .is_zero (res_zero_unused)
   );

   fp16_classify u_b_class (
      .val     (cmd_b),
      .is_nan  (b_nan_unused),
      .is_inf  (b_inf_unused),
      .is_zero (b_zero)
   );

   always_comb begin
      case (cmd_op)
         FP_ADD:  lat_sel = 4'(LAT_ADD);
         FP_SUB:  lat_sel = 4'(LAT_SUB);
         FP_MUL:  lat_sel = 4'(LAT_MUL);
         default: lat_sel = 4'(LAT_DIV);
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fp_a_d      = fp_a_q;
      fp_b_d      = fp_b_q;
      fp_sel_d    = fp_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_nan_d   = rsp_nan_q;
      rsp_dz_d    = rsp_dz_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               fp_a_d   = cmd_a;
               fp_b_d   = cmd_b;
               fp_sel_d = cmd_op;
               rsp_dz_d = (cmd_op == FP_DIV) && b_zero;
               cnt_d    = lat_sel;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Counter reaching zero marks LAT edges since accept; capture on the next one.
            if (cnt_q == '0) begin
               rsp_data_d  = fp_result;
               rsp_nan_d   = res_nan;
               rsp_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         fp_a_q      <= '0;
         fp_b_q      <= '0;
         fp_sel_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_nan_q   <= 1'b0;
         rsp_dz_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fp_a_q      <= fp_a_d;
         fp_b_q      <= fp_b_d;
         fp_sel_q    <= fp_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_nan_q   <= rsp_nan_d;
         rsp_dz_q    <= rsp_dz_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign fp_a      = fp_a_q;
   assign fp_b      = fp_b_q;
   assign fp_sel    = fp_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_nan   = rsp_nan_q;
   assign rsp_dz    = rsp_dz_q;

endmodule
